fpaddsub_norm_pack: RTL and testbench
=====================================

FPADDSUB_NORM_PACK -- requirements
Module: fpaddsub_norm_pack

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, operand presented.
REQ-004 SHALL have port in_ready, output, 1, operand accepted when in_valid & in_ready.
REQ-005 SHALL have port Sr, input, 1, result sign.
REQ-006 SHALL have port Er, input, 8, biased exponent; denormal encoded as 8'h01 with hidden bit 0.
REQ-007 SHALL have port Mr, input, 26, {carry, hidden, frac[22:0], guard}; bit 24 weight 2^(Er-127).
REQ-008 SHALL have port Sticky, input, 1, OR of bits shifted out below guard.
REQ-009 SHALL have port Z, output, 32, packed IEEE-754 single result.
REQ-010 SHALL have port out_valid, output, 1, Z valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts Z when out_valid & out_ready.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 capture + leading-zero count, S2 shift + exponent adjust, S3 round + pack; accepted operand appears on Z exactly 3 cycles later absent stalls.
REQ-013 SHALL use a global advance = ~out_valid | out_ready; in_ready = advance; all stages hold when advance=0; bubbles are not collapsed while stalled.
REQ-014 SHALL, with Mr[25]=1, shift right 1, exponent+1, new guard=Mr[1], sticky |= Mr[0].
REQ-015 SHALL, with Mr[25]=0, left-shift by min(lzc(Mr[24:0]), Er-1) and subtract shift from exponent; if hidden bit still 0 the exponent field is 0 (denormal).
REQ-016 SHALL round-to-nearest-even: increment {exp,frac} by 1 iff guard & (sticky | frac[0]); mantissa carry propagates into exponent (denormal to normal included).
REQ-017 SHALL output {Sr,8'hFF,23'h0} when final exponent >= 255 (internal exponent 9 bits wide).
REQ-018 SHALL output {Sr,31'h0} when Mr==0 and Sticky==0.
REQ-019 SHALL keep Z and out_valid stable while out_valid & ~out_ready.

Reset
REQ-020 SHALL, on rst, clear all stage valid bits, out_valid=0, Z=32'h0, flags=0; in_ready=1 the cycle after.
REQ-021 SHALL discard in-flight operands when rst asserts mid-operation; no partial result emitted.

Configuration
REQ-022 SHALL, with FPADDSUB_PACK_FLAGS_EN defined, add outputs Ovf, Unf, Inx (1 bit each, aligned with Z): overflow per REQ-017, underflow = denormal/zero result with inexact, inexact = guard|sticky before rounding.
REQ-023 SHALL, without FPADDSUB_PACK_FLAGS_EN, omit those ports and their logic entirely.

Structure
REQ-024 SHALL place widths (EXP_W=8, FRAC_W=23, MR_W=26), bias 127, and constants EXP_MAX=8'hFF, QNAN/INF patterns in shared package fpaddsub_pkg.
REQ-025 SHALL instantiate one sub-module fpaddsub_lzc26 (26-bit leading-zero counter, 5-bit count, zero flag) in S1.

Verification
REQ-026 SHALL check unity: Sr=0, Er=8'h7F, Mr=26'h1000000, Sticky=0 -> Z=32'h3F800000, out_valid 3 cycles after accept.
REQ-027 SHALL check carry and tie rounding: Er=8'h7F, Mr=26'h2000000 -> 32'h40000000; Mr=26'h1000001 -> 32'h3F800000; Mr=26'h1000003 -> 32'h3F800002.
REQ-028 SHALL check overflow: Er=8'hFE, Mr=26'h3FFFFFF -> Z=32'h7F800000 (Ovf=1 when flags enabled).
REQ-029 SHALL check denormal/zero: Er=8'h01, Mr=26'h0000002 -> 32'h00000001; Sr=1, Mr=0, Sticky=0 -> 32'h80000000.
REQ-030 SHALL check backpressure: 4 back-to-back operands, out_ready=0 for 5 cycles -> in_ready=0 after pipeline fills, Z stable, all 4 results delivered in order once out_ready=1.
REQ-031 SHALL check reset mid-flight: assert rst with 2 operands in pipe -> out_valid=0 next cycle, no stale Z emitted afterwards.

Source files
------------

// File: rtl/fpaddsub_norm_pack_pkg.sv
// Shared widths, constants and rounding helper for the add/sub normalise-and-pack pipeline.
package fpaddsub_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MR_W   = 26;
  localparam int BIAS   = 127;
  localparam int LZC_W  = 5;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [30:0]      INF_MAG  = 31'h7F80_0000;
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
  localparam logic [31:0]      POS_INF  = 32'h7F80_0000;
  localparam logic [31:0]      NEG_INF  = 32'hFF80_0000;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fpaddsub_norm_pack_lzc26.sv
// 26-bit leading-zero counter; count is 26 and zero flag set for an all-zero word.
module fpaddsub_lzc26
  import fpaddsub_pkg::*;
(
  input  logic [MR_W-1:0]  i_data,
  output logic [LZC_W-1:0] o_count,
  output logic             o_zero
);

  // Scan upward so the most significant set bit is the last one to win.
  always_comb begin
    o_count = 5'd26;
    o_zero  = (i_data == 26'd0);
    for (int i = 0; i < MR_W; i++) begin
      o_count = i_data[i] ? 5'(MR_W - 1 - i) : o_count;
    end
  end

endmodule

// File: rtl/fpaddsub_norm_pack.sv
// Normalise, round (RNE) and pack a single-precision add/sub result in three stages.
// Optional Ovf/Unf/Inx outputs are enabled with macro FPADDSUB_PACK_FLAGS_EN.
module fpaddsub_norm_pack
  import fpaddsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Sr,
  input  logic [EXP_W-1:0]  Er,
  input  logic [MR_W-1:0]   Mr,
  input  logic              Sticky,
  output logic [31:0]       Z,
  output logic              out_valid,
  input  logic              out_ready
`ifdef FPADDSUB_PACK_FLAGS_EN
  ,
  output logic              Ovf,
  output logic              Unf,
  output logic              Inx
`endif
);

  logic              w_advance;
  logic [LZC_W-1:0]  w_lzc_cnt;
  logic              w_lzc_zero;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [MR_W-1:0]   r_s1_mr;
  logic              r_s1_sticky;
  logic [LZC_W-1:0]  r_s1_lzc;

  logic [7:0]        w_max_sh;
  logic [7:0]        w_sh;
  logic [24:0]       w_norm;
  logic [8:0]        w_exp_raw;
  logic [8:0]        w_exp;
  logic              w_stk;

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic [8:0]        r_s2_exp;
  logic [23:0]       r_s2_man;
  logic              r_s2_sticky;

  logic [FRAC_W-1:0] w_frac;
  logic              w_guard;
  logic              w_inc;
  logic [31:0]       w_sum;
  logic              w_ovf;
  logic [31:0]       w_z;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  fpaddsub_lzc26 u_lzc (
    .i_data  (Mr),
    .o_count (w_lzc_cnt),
    .o_zero  (w_lzc_zero)
  );

  // Stage 1: capture operand and the leading-zero count of Mr[24:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= 8'd0;
      r_s1_mr     <= 26'd0;
      r_s1_sticky <= 1'b0;
      r_s1_lzc    <= 5'd0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= Sr;
      r_s1_exp    <= Er;
      r_s1_mr     <= Mr;
      r_s1_sticky <= Sticky;
      r_s1_lzc    <= w_lzc_zero ? 5'd25 : (w_lzc_cnt - 5'd1);
    end
  end

  // Left shift is capped at Er-1 so the exponent never drops below the denormal encoding.
  always_comb begin
    w_max_sh = (r_s1_exp == 8'd0) ? 8'd0 : (r_s1_exp - 8'd1);
    w_sh     = ({3'd0, r_s1_lzc} > w_max_sh) ? w_max_sh : {3'd0, r_s1_lzc};
    if (r_s1_mr[25]) begin
      w_norm    = r_s1_mr[25:1];
      w_stk     = r_s1_sticky | r_s1_mr[0];
      w_exp_raw = {1'b0, r_s1_exp} + 9'd1;
    end else begin
      w_norm    = r_s1_mr[24:0] << w_sh;
      w_stk     = r_s1_sticky;
      w_exp_raw = {1'b0, r_s1_exp} - {1'b0, w_sh};
    end
    w_exp = w_norm[24] ? w_exp_raw : 9'd0;
  end

  // Stage 2: register normalised mantissa and adjusted exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_exp    <= 9'd0;
      r_s2_man    <= 24'd0;
      r_s2_sticky <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_exp    <= w_exp;
      r_s2_man    <= w_norm[23:0];
      r_s2_sticky <= w_stk;
    end
  end

  // Rounding adds into {exp,frac} so a mantissa carry bumps the exponent directly.
  always_comb begin
    w_frac  = r_s2_man[23:1];
    w_guard = r_s2_man[0];
    w_inc   = rne_inc(w_guard, r_s2_sticky, w_frac[0]);
    w_sum   = {r_s2_exp, w_frac} + {31'd0, w_inc};
    w_ovf   = (w_sum[31:23] >= 9'd255);
    w_z     = w_ovf ? {r_s2_sign, INF_MAG} : {r_s2_sign, w_sum[30:0]};
  end

  // Stage 3: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Z         <= 32'd0;
    end else if (w_advance) begin
      out_valid <= r_s2_valid;
      Z         <= w_z;
    end
  end

`ifdef FPADDSUB_PACK_FLAGS_EN
  logic w_inx;
  logic w_unf;

  always_comb begin
    w_inx = w_guard | r_s2_sticky;
    w_unf = ~w_ovf & (w_sum[30:23] == 8'd0) & w_inx;
  end

  // Flags travel with Z.
  always_ff @(posedge clk) begin
    if (rst) begin
      Ovf <= 1'b0;
      Unf <= 1'b0;
      Inx <= 1'b0;
    end else if (w_advance) begin
      Ovf <= w_ovf;
      Unf <= w_unf;
      Inx <= w_inx;
    end
  end
`endif

endmodule

// File: tb/tb_fpaddsub_norm_pack.sv
// Directed-vector bench for fpaddsub_norm_pack: latency, rounding, overflow, denormals,
// backpressure and mid-flight reset. Flag checks compile in with FPADDSUB_PACK_FLAGS_EN.
module tb_fpaddsub_norm_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Sr;
  logic [7:0]  Er;
  logic [25:0] Mr;
  logic        Sticky;
  logic [31:0] Z;
  logic        out_valid;
  logic        out_ready;
`ifdef FPADDSUB_PACK_FLAGS_EN
  logic        Ovf;
  logic        Unf;
  logic        Inx;
`endif

  int n_vec = 0;
  int n_err = 0;

  fpaddsub_norm_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sr        (Sr),
    .Er        (Er),
    .Mr        (Mr),
    .Sticky    (Sticky),
    .Z         (Z),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FPADDSUB_PACK_FLAGS_EN
    ,
    .Ovf       (Ovf),
    .Unf       (Unf),
    .Inx       (Inx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // One isolated operand; out_valid must rise on the third rising edge counting the accept edge.
  task automatic run_one(input string tag, input logic sr, input logic [7:0] er,
                         input logic [25:0] mr, input logic st,
                         input logic [31:0] z_exp, input logic [2:0] flags_exp);
    @(negedge clk);
    in_valid = 1'b1; Sr = sr; Er = er; Mr = mr; Sticky = st;
    #1;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_z"}, Z, z_exp);
`ifdef FPADDSUB_PACK_FLAGS_EN
    check_eq({tag, "_flags"}, {29'd0, Ovf, Unf, Inx}, {29'd0, flags_exp});
`endif
  endtask

  logic [7:0]  bp_er [4];
  logic [25:0] bp_mr [4];
  logic [31:0] bp_z  [4];

  initial begin
    int n_in;
    int n_out;
    int n_stall;
    bit stalled;
    bit acc;
    logic [31:0] prev_z;

    rst = 1'b1; in_valid = 1'b0; Sr = 1'b0; Er = 8'd0; Mr = 26'd0; Sticky = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_z", Z, 32'd0);
`ifdef FPADDSUB_PACK_FLAGS_EN
    check_eq("rst_flags", {29'd0, Ovf, Unf, Inx}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // flags column is {Ovf, Unf, Inx}
    run_one("unity",     1'b0, 8'h7F, 26'h100_0000, 1'b0, 32'h3F80_0000, 3'b000);
    run_one("carry",     1'b0, 8'h7F, 26'h200_0000, 1'b0, 32'h4000_0000, 3'b000);
    run_one("tie_even",  1'b0, 8'h7F, 26'h100_0001, 1'b0, 32'h3F80_0000, 3'b001);
    run_one("tie_up",    1'b0, 8'h7F, 26'h100_0003, 1'b0, 32'h3F80_0002, 3'b001);
    run_one("sticky_up", 1'b0, 8'h7F, 26'h100_0001, 1'b1, 32'h3F80_0001, 3'b001);
    run_one("overflow",  1'b0, 8'hFE, 26'h3FF_FFFF, 1'b0, 32'h7F80_0000, 3'b101);
    run_one("denorm",    1'b0, 8'h01, 26'h000_0002, 1'b0, 32'h0000_0001, 3'b000);
    run_one("neg_zero",  1'b1, 8'h01, 26'h000_0000, 1'b0, 32'h8000_0000, 3'b000);
    run_one("den_to_nrm",1'b0, 8'h01, 26'h0FF_FFFF, 1'b0, 32'h0080_0000, 3'b001);
    run_one("lshift",    1'b0, 8'h80, 26'h040_0000, 1'b0, 32'h3F00_0000, 3'b000);
    run_one("lsh_capped",1'b1, 8'h03, 26'h000_0100, 1'b0, 32'h8000_0200, 3'b000);

    // Backpressure: four back-to-back operands, sink stalled for five cycles once full.
    bp_er[0] = 8'h7F; bp_mr[0] = 26'h100_0000; bp_z[0] = 32'h3F80_0000;
    bp_er[1] = 8'h7F; bp_mr[1] = 26'h200_0000; bp_z[1] = 32'h4000_0000;
    bp_er[2] = 8'h7F; bp_mr[2] = 26'h100_0003; bp_z[2] = 32'h3F80_0002;
    bp_er[3] = 8'h01; bp_mr[3] = 26'h000_0002; bp_z[3] = 32'h0000_0001;
    n_in = 0; n_out = 0; n_stall = 0; stalled = 1'b0; prev_z = 32'd0;
    Sr = 1'b0; Sticky = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = (c >= 8);
      if (n_in < 4) begin
        in_valid = 1'b1; Er = bp_er[n_in]; Mr = bp_mr[n_in];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        n_stall++;
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        if (stalled) check_eq("bp_z_hold", Z, prev_z);
        prev_z  = Z;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (n_out < 4) check_eq("bp_z_order", Z, bp_z[n_out]);
        else check_eq("bp_extra_out", {31'd0, out_valid}, 32'd0);
        n_out++;
      end
      acc = in_valid && in_ready;
      if (acc) n_in++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_delivered", n_out, 32'd4);
    check_eq("bp_stall_cycles", n_stall, 32'd5);

    // Reset with two operands in flight.
    @(negedge clk);
    in_valid = 1'b1; Sr = 1'b0; Er = 8'h7F; Mr = 26'h100_0000; Sticky = 1'b0;
    @(negedge clk);
    Mr = 26'h200_0000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_z", Z, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("mid_rst_stale", {31'd0, out_valid}, 32'd0);
    end
    run_one("post_rst", 1'b0, 8'h80, 26'h100_0000, 1'b0, 32'h4000_0000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
